dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have parameter LOCK_MAX, default 16, meaning maximum consecutive locked cycles before forced release.
REQ-004 Clocking is one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  sole clock, all state on rising edge.
REQ-006 Port: rst  input  1  asynchronous active-high reset.
REQ-007 Ports per requester n in {0 = core LSU, 1 = DMA}: req_n in 1 (access request); lock_n in 1 (hold ownership); we_n in 1 (store); funct3_n in 3 (RISC-V load/store size code); addr_n in ADDR_WIDTH (byte address); wdata_n in DATA_WIDTH (store data); gnt_n out 1 (request accepted this cycle); rvalid_n out 1 (response valid); rdata_n out DATA_WIDTH (load data); err_n out 1 (response is an error).
REQ-008 Memory-side ports: mem_wr_en out 1; mem_funct3 out 3; mem_addr out ADDR_WIDTH; mem_wr_data out DATA_WIDTH; mem_rd_data in DATA_WIDTH (combinational read data for the current mem_addr/mem_funct3).

Function
REQ-009 SHALL accept at most one access per cycle; gnt_n is combinational, asserted only when req_n is high and port n wins arbitration.
REQ-010 SHALL drive mem_* from the granted port in the grant cycle; with no grant, mem_wr_en = 0 and mem_addr/mem_funct3/mem_wr_data = 0.
REQ-011 SHALL register each response: rvalid_n asserts exactly 1 cycle after gnt_n, for 1 cycle; rdata_n holds the mem_rd_data captured in the grant cycle for loads, and 0 for stores and errors.
REQ-012 Requesters hold req/addr/data stable until gnt; the arbiter does not queue requests.
REQ-013 Arbitration SHALL be round-robin: a last-grant pointer selects priority; with both ports requesting, the port not granted last wins; after reset port 0 has priority.
REQ-014 Legal loads SHALL be funct3 000, 001, 010, 100, 101; legal stores SHALL be 000, 001, 010.
REQ-015 An access with illegal funct3, a halfword with addr[0] = 1, or a word with addr[1:0] != 00 SHALL still be granted, SHALL force mem_wr_en = 0, and SHALL return rvalid with err = 1 and rdata = 0.
REQ-016 The FSM SHALL have states IDLE and LOCKED(n). IDLE -> LOCKED(n) on gnt_n with lock_n = 1. LOCKED(n) -> IDLE when lock_n = 0, or when the lock counter reaches LOCK_MAX.
REQ-017 In LOCKED(n), only port n SHALL be grantable; the other port's gnt stays 0.
REQ-018 The lock counter SHALL reset to 0 on entering LOCKED and increment every locked cycle; a forced release SHALL give the other port priority on the next cycle.
REQ-019 On simultaneous requests in the cycle a forced release occurs, the non-owner SHALL win.
REQ-020 The round-robin pointer SHALL update on every grant, including error grants.

Reset
REQ-021 While rst = 1, all outputs SHALL be 0 and the FSM SHALL be IDLE, with the pointer at port 0 priority and the lock counter at 0.
REQ-022 Reset asserted between a grant and its response SHALL drop that response; no rvalid appears after reset release for pre-reset grants.

Structure
REQ-023 The funct3 size codes (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state encoding SHALL live in a shared package with the datapath.
REQ-024 An access legality checker SHALL be one sub-module, dmem_access_check, taking funct3, we, and addr[1:0] and producing a legal flag; it is instantiated once on the muxed request.

Verification
REQ-025 Port 0 alone issues SW addr 0x10 wdata 0xDEADBEEF, then LW addr 0x10 -> gnt_0 in the same cycle, rvalid_0 next cycle, and rdata_0 = 0xDEADBEEF.
REQ-026 Both ports hold req for 4 cycles, no lock -> grants alternate 0, 1, 0, 1.
REQ-027 Port 1 requests with lock_1 held and port 0 requests continuously -> gnt_0 = 0 for 16 cycles, then forced release and gnt_0 the next cycle.
REQ-028 LH at addr 0x13 and SW at addr 0x12 -> err = 1, rdata = 0, mem_wr_en = 0, and the memory word is unchanged.
REQ-029 Store funct3 100 -> err = 1 and no write.
REQ-030 rst pulsed in the cycle after a granted LW -> no rvalid after reset, and the next dual request grants port 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: RISC-V load/store
// size codes, arbiter FSM state encoding and small size-decoding helpers.
package dmem_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_LOCKED0 = 2'b01;
  localparam logic [1:0] ST_LOCKED1 = 2'b10;

  function automatic logic [1:0] st_locked(input logic port);
    return port ? ST_LOCKED1 : ST_LOCKED0;
  endfunction

  // The low two funct3 bits encode the access size for both loads and stores.
  function automatic logic size_is_half(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

  function automatic logic size_is_word(input logic [2:0] funct3);
    return funct3[1:0] == 2'b10;
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Access legality: valid size code for the direction, and natural alignment
// for halfword and word accesses.
module dmem_access_check
  import dmem_arbiter_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       we_i,
  input  logic [1:0] addr_lo_i,
  output logic       legal_o
);

  logic code_ok;
  logic align_ok;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    code_ok  = 1'b0;
    align_ok = 1'b1;
    if (we_i) begin
      case (funct3_i)
        F3_SB, F3_SH, F3_SW: code_ok = 1'b1;
        default:             code_ok = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: code_ok = 1'b1;
        default:                             code_ok = 1'b0;
      endcase
    end
    if (size_is_half(funct3_i) && addr_lo_i[0]) align_ok = 1'b0;
    if (size_is_word(funct3_i) && (addr_lo_i != 2'b00)) align_ok = 1'b0;
  end

  assign legal_o = code_ok & align_ok;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (0 = core LSU, 1 = DMA) data-memory arbiter: round-robin grant,
// bounded ownership locks, legality checking and registered responses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_0,
  input  logic                  lock_0,
  input  logic                  we_0,
  input  logic [2:0]            funct3_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  gnt_0,
  output logic                  rvalid_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  err_0,

  input  logic                  req_1,
  input  logic                  lock_1,
  input  logic                  we_1,
  input  logic [2:0]            funct3_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  gnt_1,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  err_1,

  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [1:0]            state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  gnt0_w, gnt1_w, any_gnt, sel;
  logic                  sel_we, sel_lock, legal;
  logic [2:0]            sel_funct3;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  locked, owner, owner_lock, force_release;

  // Grants are held low during reset so every output reads 0 while rst is high.
  always_comb begin
    gnt0_w = 1'b0;
    gnt1_w = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_LOCKED0: gnt0_w = req_0;
        ST_LOCKED1: gnt1_w = req_1;
        default: begin
          if (req_0 && req_1) begin
            gnt0_w = last_gnt_q;
            gnt1_w = !last_gnt_q;
          end else begin
            gnt0_w = req_0;
            gnt1_w = req_1;
          end
        end
      endcase
    end
  end

  assign any_gnt    = gnt0_w | gnt1_w;
  assign sel        = gnt1_w;
  assign sel_we     = sel ? we_1     : we_0;
  assign sel_lock   = sel ? lock_1   : lock_0;
  assign sel_funct3 = sel ? funct3_1 : funct3_0;
  assign sel_addr   = sel ? addr_1   : addr_0;
  assign sel_wdata  = sel ? wdata_1  : wdata_0;

  dmem_access_check u_check (
    .funct3_i  (sel_funct3),
    .we_i      (sel_we),
    .addr_lo_i (sel_addr[1:0]),
    .legal_o   (legal)
  );

  assign mem_wr_en   = any_gnt & sel_we & legal;
  assign mem_funct3  = any_gnt ? sel_funct3 : 3'b000;
  assign mem_addr    = any_gnt ? sel_addr   : '0;
  assign mem_wr_data = any_gnt ? sel_wdata  : '0;

  assign locked        = (state_q != ST_IDLE);
  assign owner         = (state_q == ST_LOCKED1);
  assign owner_lock    = owner ? lock_1 : lock_0;
  assign force_release = locked && (lock_cnt_q == CNT_W'(LOCK_MAX - 1));

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_gnt_d = last_gnt_q;
    if (any_gnt) last_gnt_d = sel;
    if (!locked) begin
      if (any_gnt && sel_lock) begin
        state_d    = st_locked(sel);
        lock_cnt_d = '0;
      end
    end else begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
      if (!owner_lock || force_release) begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
      // Marking the owner as last granted hands priority to the other port.
      if (force_release) last_gnt_d = owner;
    end
  end

  always_comb begin
    rvalid_d = {gnt1_w, gnt0_w};
    err_d    = any_gnt & !legal;
    rdata_d  = (any_gnt && !sel_we && legal) ? mem_rd_data : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      rvalid_q   <= 2'b00;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign gnt_0    = gnt0_w;
  assign gnt_1    = gnt1_w;
  assign rvalid_0 = rvalid_q[0];
  assign rvalid_1 = rvalid_q[1];
  assign err_0    = rvalid_q[0] & err_q;
  assign err_1    = rvalid_q[1] & err_q;
  assign rdata_0  = rvalid_q[0] ? rdata_q : '0;
  assign rdata_1  = rvalid_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressed memory device plus a cycle-level
// reference model of grant, lock and response behaviour.
module tb_dmem_arbiter;

  localparam int DW       = 32;
  localparam int AW       = 32;
  localparam int LOCK_MAX = 16;

  logic clk = 1'b0;
  logic rst;

  logic          req_0, lock_0, we_0, gnt_0, rvalid_0, err_0;
  logic [2:0]    funct3_0;
  logic [AW-1:0] addr_0;
  logic [DW-1:0] wdata_0, rdata_0;
  logic          req_1, lock_1, we_1, gnt_1, rvalid_1, err_1;
  logic [2:0]    funct3_1;
  logic [AW-1:0] addr_1;
  logic [DW-1:0] wdata_1, rdata_1;
  logic          mem_wr_en;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .lock_0(lock_0), .we_0(we_0), .funct3_0(funct3_0), .addr_0(addr_0),
    .wdata_0(wdata_0), .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0), .err_0(err_0),
    .req_1(req_1), .lock_1(lock_1), .we_1(we_1), .funct3_1(funct3_1), .addr_1(addr_1),
    .wdata_1(wdata_1), .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1), .err_1(err_1),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // RISC-V memory semantics shared by the device and the expected-memory model.
  function automatic logic [31:0] load_result(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    case (f3)
      3'b000:  r[8*a +: 8] = d[7:0];
      3'b001:  if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      3'b010:  r = d;
      default: r = {~w[31:1], w[0]};
    endcase
    return r;
  endfunction

  function automatic bit legal_ref(input bit w, input logic [2:0] f3, input logic [31:0] a);
    bit code_ok;
    int size;
    code_ok = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size    = 1 << f3[1:0];
    return code_ok && ((a % size) == 0);
  endfunction

  logic [31:0] dev_mem [64];
  logic        fill_en = 1'b0;
  logic [5:0]  fill_idx;
  logic [31:0] fill_data;

  always @(posedge clk) begin
    if (fill_en) dev_mem[fill_idx] <= fill_data;
    else if (mem_wr_en)
      dev_mem[mem_addr[7:2]] <= store_merge(dev_mem[mem_addr[7:2]], mem_wr_data, mem_funct3, mem_addr[1:0]);
  end

  assign mem_rd_data = load_result(dev_mem[mem_addr[7:2]], mem_funct3, mem_addr[1:0]);

  // Reference model: owner (-1 = none), cycles held, port with priority, pending response.
  logic [31:0] model_mem [64];
  int          m_owner, m_held, m_prio, m_last;
  bit          p_rv0, p_rv1, p_err;
  logic [31:0] p_rdata;
  logic [1:0]  obs_gnt;
  logic [2:0]  ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_prio = 0; m_last = -1;
    p_rv0 = 0; p_rv1 = 0; p_err = 0; p_rdata = '0;
  endtask

  task automatic drive(input int p, input bit rq, input bit lk, input bit w,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req_0 = rq; lock_0 = lk; we_0 = w; funct3_0 = f3; addr_0 = a; wdata_0 = d;
    end else begin
      req_1 = rq; lock_1 = lk; we_1 = w; funct3_1 = f3; addr_1 = a; wdata_1 = d;
    end
  endtask

  task automatic idle_all();
    drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
  endtask

  // One clock cycle: compare DUT against the model at the falling edge, then advance the model.
  task automatic run_cycle(input string tag);
    int          g;
    bit          w, lg;
    logic [2:0]  f3;
    logic [31:0] a, d;
    logic [67:0] exp_bus, act_bus;
    @(negedge clk);
    g = -1;
    if (m_owner >= 0) begin
      if ((m_owner == 0 && req_0) || (m_owner == 1 && req_1)) g = m_owner;
    end else if (req_0 && req_1) g = m_prio;
    else if (req_0) g = 0;
    else if (req_1) g = 1;
    w  = (g == 1) ? we_1     : we_0;
    f3 = (g == 1) ? funct3_1 : funct3_0;
    a  = (g == 1) ? addr_1   : addr_0;
    d  = (g == 1) ? wdata_1  : wdata_0;
    lg = (g >= 0) && legal_ref(w, f3, a);

    obs_gnt = {gnt_1, gnt_0};
    n_checks++;
    if (obs_gnt !== {g == 1, g == 0}) begin
      n_fail++;
      $display("FAIL %s grant: got %b expected %b", tag, obs_gnt, {g == 1, g == 0});
    end
    exp_bus = (g >= 0) ? {w && lg, f3, a, d} : '0;
    act_bus = {mem_wr_en, mem_funct3, mem_addr, mem_wr_data};
    n_checks++;
    if (act_bus !== exp_bus) begin
      n_fail++;
      $display("FAIL %s mem bus {wr,f3,addr,wdata}: got %h expected %h", tag, act_bus, exp_bus);
    end
    n_checks++;
    if ({rvalid_1, rvalid_0} !== {p_rv1, p_rv0}) begin
      n_fail++;
      $display("FAIL %s rvalid: got %b expected %b", tag, {rvalid_1, rvalid_0}, {p_rv1, p_rv0});
    end
    if (p_rv0) begin
      n_checks++;
      if ({err_0, rdata_0} !== {p_err, p_rdata}) begin
        n_fail++;
        $display("FAIL %s resp0 err/rdata: got %b/%h expected %b/%h", tag, err_0, rdata_0, p_err, p_rdata);
      end
    end
    if (p_rv1) begin
      n_checks++;
      if ({err_1, rdata_1} !== {p_err, p_rdata}) begin
        n_fail++;
        $display("FAIL %s resp1 err/rdata: got %b/%h expected %b/%h", tag, err_1, rdata_1, p_err, p_rdata);
      end
    end

    p_rv0   = (g == 0);
    p_rv1   = (g == 1);
    p_err   = (g >= 0) && !lg;
    p_rdata = (g >= 0 && !w && lg) ? load_result(model_mem[a[7:2]], f3, a[1:0]) : 32'h0;
    if (g >= 0 && w && lg) model_mem[a[7:2]] = store_merge(model_mem[a[7:2]], d, f3, a[1:0]);
    m_last = g;
    if (g >= 0) m_prio = 1 - g;
    if (m_owner >= 0) begin
      m_held++;
      if (m_held == LOCK_MAX) begin
        m_prio  = 1 - m_owner;
        m_owner = -1;
      end else if (!((m_owner == 0) ? lock_0 : lock_1)) m_owner = -1;
    end else if (g >= 0 && ((g == 0) ? lock_0 : lock_1)) begin
      m_owner = g;
      m_held  = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 1, 3'b010, 32'h10, 32'h1111_2222);
    drive(1, 1, 1, 0, 3'b010, 32'h20, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1, rdata_0, rdata_1,
         mem_wr_en, mem_funct3, mem_addr, mem_wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got gnt=%b%b rv=%b%b err=%b%b wr=%b addr=%h expected all zero",
               gnt_1, gnt_0, rvalid_1, rvalid_0, err_1, err_0, mem_wr_en, mem_addr);
    end
    idle_all();
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    run_cycle("reset_idle");
  endtask

  task automatic test_store_load();
    drive(0, 1, 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    run_cycle("sw_0x10");
    drive(0, 1, 0, 0, 3'b010, 32'h10, 32'h0);
    run_cycle("lw_0x10");
    n_checks++;
    if (obs_gnt !== 2'b01 || rvalid_0 !== 1'b1 || rdata_0 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL store_load: got gnt=%b rvalid=%b rdata=%h expected 01/1/deadbeef", obs_gnt, rvalid_0, rdata_0);
    end
    idle_all();
    run_cycle("lw_resp");
  endtask

  task automatic test_round_robin();
    logic [7:0] seq;
    apply_reset();
    seq = '0;
    drive(0, 1, 0, 0, 3'b010, 32'h40, 32'h0);
    drive(1, 1, 0, 0, 3'b010, 32'h80, 32'h0);
    for (int i = 0; i < 4; i++) begin
      run_cycle("round_robin");
      seq = {seq[5:0], obs_gnt};
      if (m_last == 0) addr_0 = addr_0 + 32'd4;
      if (m_last == 1) addr_1 = addr_1 + 32'd4;
    end
    n_checks++;
    if (seq !== 8'b01_10_01_10) begin
      n_fail++;
      $display("FAIL round_robin sequence: got %b expected 01100110", seq);
    end
    idle_all();
    run_cycle("rr_drain");
  endtask

  task automatic test_lock_release();
    int denied;
    bit seen;
    apply_reset();
    drive(1, 1, 1, 0, 3'b010, 32'h20, 32'h0);
    run_cycle("lock_take");
    n_checks++;
    if (obs_gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_take grant: got %b expected 10", obs_gnt);
    end
    drive(0, 1, 0, 0, 3'b010, 32'h30, 32'h0);
    denied = 0;
    seen   = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      run_cycle("lock_hold");
      if (obs_gnt[0]) seen = 1;
      else denied++;
    end
    n_checks++;
    if (!seen || denied != LOCK_MAX) begin
      n_fail++;
      $display("FAIL lock_release: got gnt_0 seen=%0d after %0d denied cycles expected seen=1 after 16", seen, denied);
    end
    idle_all();
    repeat (2) run_cycle("lock_drain");
  endtask

  task automatic test_errors();
    idle_all();
    drive(1, 1, 0, 0, 3'b001, 32'h13, 32'h0);
    run_cycle("lh_0x13");
    drive(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    n_checks++;
    if (rvalid_1 !== 1'b1 || err_1 !== 1'b1 || rdata_1 !== 32'h0) begin
      n_fail++;
      $display("FAIL lh_misaligned: got rv=%b err=%b rdata=%h expected 1/1/0", rvalid_1, err_1, rdata_1);
    end
    drive(0, 1, 0, 1, 3'b010, 32'h12, 32'h1234_5678);
    run_cycle("sw_0x12");
    n_checks++;
    if (rvalid_0 !== 1'b1 || err_0 !== 1'b1 || rdata_0 !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_misaligned: got rv=%b err=%b rdata=%h expected 1/1/0", rvalid_0, err_0, rdata_0);
    end
    drive(0, 1, 0, 1, 3'b100, 32'h10, 32'hCAFE_F00D);
    run_cycle("store_f3_100");
    n_checks++;
    if (rvalid_0 !== 1'b1 || err_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL store_f3_100: got rv=%b err=%b expected 1/1", rvalid_0, err_0);
    end
    idle_all();
    run_cycle("err_drain");
    n_checks++;
    if (dev_mem[4] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL err_no_write: got word 0x10 = %h expected deadbeef", dev_mem[4]);
    end
  endtask

  task automatic test_reset_drop();
    idle_all();
    drive(0, 1, 0, 0, 3'b010, 32'h10, 32'h0);
    run_cycle("lw_pre_reset");
    idle_all();
    rst = 1'b1;
    #1;
    n_checks++;
    if (rvalid_0 !== 1'b0 || rdata_0 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_drop in reset: got rvalid=%b rdata=%h expected 0/0", rvalid_0, rdata_0);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    repeat (3) run_cycle("post_reset_quiet");
    drive(0, 1, 0, 0, 3'b010, 32'h50, 32'h0);
    drive(1, 1, 0, 0, 3'b010, 32'h60, 32'h0);
    run_cycle("dual_after_reset");
    n_checks++;
    if (obs_gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL dual_after_reset: got %b expected 01", obs_gnt);
    end
    idle_all();
    run_cycle("reset_drop_drain");
  endtask

  task automatic rand_txn(input int p);
    bit          w;
    logic [2:0]  f3;
    logic [31:0] a;
    w = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 4) != 0) f3 = w ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
    else f3 = 3'($urandom_range(0, 7));
    a = {24'h0, 8'($urandom_range(0, 255))};
    if ($urandom_range(0, 3) != 0) begin
      if (f3[1]) a[1:0] = 2'b00;
      else if (f3[0]) a[0] = 1'b0;
    end
    if ($urandom_range(0, 7) == 0) a[31:8] = 24'($urandom);
    drive(p, 1, $urandom_range(0, 9) < 2, w, f3, a, $urandom);
  endtask

  task automatic test_random(input int cycles);
    bit busy0, busy1;
    busy0 = 0;
    busy1 = 0;
    for (int i = 0; i < cycles; i++) begin
      if (!busy0) begin
        if ($urandom_range(0, 9) < 6) begin rand_txn(0); busy0 = 1; end
        else drive(0, 0, $urandom_range(0, 3) == 0, 0, 3'b000, 32'h0, 32'h0);
      end
      if (!busy1) begin
        if ($urandom_range(0, 9) < 6) begin rand_txn(1); busy1 = 1; end
        else drive(1, 0, $urandom_range(0, 3) == 0, 0, 3'b000, 32'h0, 32'h0);
      end
      run_cycle("random");
      if (m_last == 0) busy0 = 0;
      if (m_last == 1) busy1 = 0;
    end
    idle_all();
    repeat (2) run_cycle("random_drain");
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (dev_mem[i] !== model_mem[i]) begin
        n_fail++;
        $display("FAIL memory word %0d: got %h expected %h", i, dev_mem[i], model_mem[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    model_reset();
    fill_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      fill_idx     = 6'(i);
      fill_data    = $urandom;
      model_mem[i] = fill_data;
      @(posedge clk); #1;
    end
    fill_en = 1'b0;

    test_reset();
    test_store_load();
    test_round_robin();
    test_lock_release();
    test_errors();
    test_reset_drop();
    test_random(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
